// File: rtl/addr_accept_pkg.sv
// Shared types and constants for the address accept queue.
// No logic: widths, the stage-1 register layout and a saturating increment helper.
// Backpressure: not applicable.
package addr_accept_pkg;

    localparam int ADDR_W    = 25;  // request address bits [27:3]
    localparam int CNT_W     = 8;   // reject counter width
    localparam int DEPTH_DEF = 4;   // default queue depth

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    localparam cnt_t CNT_MAX = '1;

    // Request held for one cycle so its address lines up with the decode
    // stage's registered hit.
    typedef struct packed {
        logic  vld;
        addr_t addr;
    } s1_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == CNT_MAX) ? v : v + cnt_t'(1);
    endfunction

endpackage

// File: rtl/addr_fifo.sv
// Address FIFO: DEPTH-entry storage with wrap-bit read/write pointers.
// Latency: push visible at head the cycle after the write; head is fall-through.
// Backpressure: a push while full is dropped unless a pop frees a slot that same cycle.
//
// Ports:
//   go, rst_n        clock, synchronous active-low reset (pointers only)
//   push, push_dat   write request and data
//   pop              read request, ignored when empty
//   head_dat         entry at the read pointer (undefined when empty)
//   full, empty      occupancy flags
//   count            number of valid entries, 0..DEPTH
module addr_fifo
    import addr_accept_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEF,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              go,
    input  logic              rst_n,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_dat,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_dat,
    output logic              full,
    output logic              empty,
    output logic [PTR_W:0]    count
);

    localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

    // The extra MSB on each pointer is a lap bit: equal low bits with
    // different lap bits means full, fully equal pointers means empty.
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    addr_t          mem_q [DEPTH];
    addr_t          mem_d [DEPTH];
    logic           wr_en;
    logic           rd_en;

    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        count = wr_ptr_q - rd_ptr_q;

        rd_en = pop & ~empty;
        // A pop in the same cycle frees the slot the push needs.
        wr_en = push & (~full | rd_en);

        wr_ptr_d = wr_en ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = rd_en ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = push_dat;
        end

        head_dat = mem_q[rd_ptr_q[PTR_W-1:0]];
    end

    always_ff @(posedge go) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers decide what is valid.
    always_ff @(posedge go) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/addr_accept_queue.sv
// Address accept queue: registers requests, keeps those the decode stage hits, counts rejects.
// Latency: req_vld in cycle N, hit in N+1, out_vld at N+2 at the earliest (fall-through head).
// Backpressure: full reserves a slot for the in-flight request; req_vld while full is dropped and sets ovf.
//
// Ports:
//   go, rst_n            clock, synchronous active-low reset
//   req_vld, req_addr    upstream request (address bits [27:3])
//   hit                  decode-stage qualify for the request presented one cycle earlier
//   full                 upstream must hold off req_vld
//   out_vld, out_addr    queue head; out_addr reads zero when nothing is valid
//   out_rdy              consumer takes the head
//   rej_cnt              saturating count of requests that missed
//   ovf                  sticky: a request arrived while full
module addr_accept_queue
    import addr_accept_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEF,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              go,
    input  logic              rst_n,
    input  logic              req_vld,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              hit,
    output logic              full,
    output logic              out_vld,
    output logic [ADDR_W-1:0] out_addr,
    input  logic              out_rdy,
    output logic [CNT_W-1:0]  rej_cnt,
    output logic              ovf
);

    localparam logic [PTR_W:0] LAST_FREE = (PTR_W+1)'(DEPTH-1);

    s1_t            s1_q, s1_d;
    cnt_t           rej_cnt_q, rej_cnt_d;
    logic           ovf_q, ovf_d;

    logic           full_int;
    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [PTR_W:0] fifo_count;
    addr_t          fifo_head;

    always_comb begin
        // count + s1_vld >= DEPTH. Because the in-flight slot is always
        // reserved, count never exceeds DEPTH, so this reduces to: the FIFO
        // is already full, or one slot is left and a request is in flight.
        full_int = fifo_full | ((fifo_count == LAST_FREE) & s1_q.vld);

        fifo_push = s1_q.vld & hit;
        fifo_pop  = ~fifo_empty & out_rdy;

        s1_d.vld  = req_vld & ~full_int;
        s1_d.addr = req_addr;

        rej_cnt_d = rej_cnt_q;
        if (s1_q.vld & ~hit) begin
            rej_cnt_d = sat_inc(rej_cnt_q);
        end

        ovf_d = ovf_q | (req_vld & full_int);

        // Outputs are forced quiet while reset is held so they are defined
        // even before the first reset edge has cleared the pointers.
        full     = rst_n & full_int;
        out_vld  = rst_n & ~fifo_empty;
        out_addr = (rst_n & ~fifo_empty) ? fifo_head : '0;
        rej_cnt  = rej_cnt_q;
        ovf      = ovf_q;
    end

    always_ff @(posedge go) begin
        if (!rst_n) begin
            s1_q      <= '0;
            rej_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            rej_cnt_q <= rej_cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    addr_fifo #(
        .DEPTH    (DEPTH)
    ) u_fifo (
        .go       (go),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_dat (s1_q.addr),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

endmodule
